// File: rtl/nios2_ls_pio_pkg.sv
// Shared register map and data-update helpers for the LED PIO with blink support.
package nios2_ls_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_SET      = 3'd1;
  localparam logic [2:0] ADDR_CLEAR    = 3'd2;
  localparam logic [2:0] ADDR_TOGGLE   = 3'd3;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd4;
  localparam logic [2:0] ADDR_PERIOD   = 3'd5;
  localparam logic [2:0] ADDR_STATUS   = 3'd6;
  localparam logic [2:0] ADDR_RSVD     = 3'd7;

  localparam int STATUS_PHASE_BIT  = 0;
  localparam int STATUS_ACTIVE_BIT = 1;

  // Encoding matches address[1:0] for the four DATA-modifying addresses.
  typedef enum logic [1:0] {
    DOP_LOAD   = 2'd0,
    DOP_SET    = 2'd1,
    DOP_CLEAR  = 2'd2,
    DOP_TOGGLE = 2'd3
  } data_op_e;

  function automatic logic [31:0] apply_data_op(input data_op_e   op,
                                                input logic [31:0] cur,
                                                input logic [31:0] wdata);
    logic [31:0] res;
    res = cur;
    case (op)
      DOP_LOAD:   res = wdata;
      DOP_SET:    res = cur | wdata;
      DOP_CLEAR:  res = cur & ~wdata;
      DOP_TOGGLE: res = cur ^ wdata;
      default:    res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/nios2_ls_blink_prescaler.sv
// Blink prescaler: counts 0..period-1 and toggles phase on each wrap; idle when period is 0.
module nios2_ls_blink_prescaler #(
  parameter int unsigned PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PERIOD_W-1:0] period,
  input  logic                restart,
  output logic                phase,
  output logic                phase_next
);

  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic                phase_q, phase_d;

  // restart wins over the wrap so a shorter new period never waits for a wrap-around.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart || (period == '0)) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == (period - PERIOD_W'(1))) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + PERIOD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase      = phase_q;
  assign phase_next = phase_d;

endmodule

// File: rtl/nios2_ls_pio_led_blink.sv
// Avalon-MM output PIO for LEDs with set/clear/toggle aliases and per-bit blinking.
module nios2_ls_pio_led_blink
  import nios2_ls_pio_pkg::*;
#(
  parameter int unsigned       WIDTH       = 9,
  parameter int unsigned       PERIOD_W    = 24,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  // Bus: a write is accepted on every clk edge with chipselect && !write_n (no
  // wait states); readdata is a pure function of address and current registers.
  logic                wr_en;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [WIDTH-1:0]    blink_q, blink_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic                restart;
  logic                phase, phase_next;
  logic [31:0]         rdata;

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    data_d   = data_q;
    blink_d  = blink_q;
    period_d = period_q;
    restart  = 1'b0;
    if (wr_en) begin
      case (address)
        ADDR_DATA, ADDR_SET, ADDR_CLEAR, ADDR_TOGGLE:
          data_d = WIDTH'(apply_data_op(data_op_e'(address[1:0]), 32'(data_q), writedata));
        ADDR_BLINK_EN:
          blink_d = writedata[WIDTH-1:0];
        ADDR_PERIOD: begin
          period_d = writedata[PERIOD_W-1:0];
          restart  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  nios2_ls_blink_prescaler #(
    .PERIOD_W (PERIOD_W)
  ) u_prescaler (
    .clk        (clk),
    .reset      (reset),
    .period     (period_q),
    .restart    (restart),
    .phase      (phase),
    .phase_next (phase_next)
  );

  // The output flop is loaded from next-state values so it stays aligned with DATA/BLINK_EN/phase.
  assign out_d = data_d ^ (blink_d & {WIDTH{phase_next}});

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= RESET_VALUE;
      blink_q  <= '0;
      period_q <= '0;
      out_q    <= RESET_VALUE;
    end else begin
      data_q   <= data_d;
      blink_q  <= blink_d;
      period_q <= period_d;
      out_q    <= out_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (address)
      ADDR_DATA, ADDR_SET, ADDR_CLEAR, ADDR_TOGGLE:
        rdata[WIDTH-1:0] = data_q;
      ADDR_BLINK_EN:
        rdata[WIDTH-1:0] = blink_q;
      ADDR_PERIOD:
        rdata[PERIOD_W-1:0] = period_q;
      ADDR_STATUS: begin
        rdata[STATUS_PHASE_BIT]  = phase;
        rdata[STATUS_ACTIVE_BIT] = (period_q != '0);
      end
      default: rdata = '0;
    endcase
  end

  assign readdata = rdata;
  assign out_port = out_q;

endmodule

// File: tb/tb_nios2_ls_pio_led_blink.sv
// Bench for nios2_ls_pio_led_blink: directed table, blink corner sequences, random vs model.
module tb_nios2_ls_pio_led_blink;

  localparam int unsigned W  = 9;
  localparam int unsigned PW = 24;
  localparam logic [W-1:0] RV = 9'h0A5;

  logic          clk;
  logic          reset;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [W-1:0]  out_port;

  nios2_ls_pio_led_blink #(
    .WIDTH       (W),
    .PERIOD_W    (PW),
    .RESET_VALUE (RV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: phase derived from edges elapsed since the last restart
  logic [W-1:0]  m_data;
  logic [W-1:0]  m_blink;
  logic [PW-1:0] m_period;
  int unsigned   m_k;
  logic [W-1:0]  exp_q[$];

  int checks;
  int failures;

  function automatic logic m_phase();
    int unsigned p;
    p = int'(m_period);
    if (p == 0) return 1'b0;
    return ((m_k / p) % 2) == 1;
  endfunction

  function automatic logic [W-1:0] m_out();
    return m_data ^ (m_blink & {W{m_phase()}});
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      3'd0, 3'd1, 3'd2, 3'd3: r[W-1:0] = m_data;
      3'd4: r[W-1:0] = m_blink;
      3'd5: r[PW-1:0] = m_period;
      3'd6: begin
        r[0] = m_phase();
        r[1] = (m_period != 0);
      end
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic model_step(input logic rst, input logic wr, input logic [2:0] a,
                            input logic [31:0] wd);
    if (rst) begin
      m_data   = RV;
      m_blink  = '0;
      m_period = '0;
      m_k      = 0;
    end else begin
      if (wr) begin
        case (a)
          3'd0: m_data = wd[W-1:0];
          3'd1: m_data = m_data | wd[W-1:0];
          3'd2: m_data = m_data & ~wd[W-1:0];
          3'd3: m_data = m_data ^ wd[W-1:0];
          3'd4: m_blink = wd[W-1:0];
          3'd5: m_period = wd[PW-1:0];
          default: ;
        endcase
      end
      if (wr && a == 3'd5) m_k = 0;
      else m_k = m_k + 1;
    end
    exp_q.push_back(m_out());
  endtask

  // driver tasks
  task automatic cycle(input logic rst, input logic wr, input logic [2:0] a,
                       input logic [31:0] wd);
    reset      = rst;
    chipselect = wr;
    write_n    = ~wr;
    address    = a;
    writedata  = wd;
    @(posedge clk);
    model_step(rst, wr, a, wd);
    #1;
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic read_chk(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    chk(name, readdata, exp);
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  a;
    logic [31:0] wd;
    logic [W-1:0] exp_out;
    logic [2:0]  ra;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[10];

  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;

    vecs[0] = '{1'b1, 3'd0, 32'h1F0, 9'h1F0, 3'd0, 32'h1F0};
    vecs[1] = '{1'b1, 3'd1, 32'h00F, 9'h1FF, 3'd1, 32'h1FF};
    vecs[2] = '{1'b1, 3'd2, 32'h030, 9'h1CF, 3'd2, 32'h1CF};
    vecs[3] = '{1'b1, 3'd3, 32'h101, 9'h0CE, 3'd3, 32'h0CE};
    vecs[4] = '{1'b0, 3'd0, 32'h000, 9'h0CE, 3'd1, 32'h0CE};
    vecs[5] = '{1'b0, 3'd0, 32'h000, 9'h0CE, 3'd4, 32'h000};
    vecs[6] = '{1'b0, 3'd0, 32'h000, 9'h0CE, 3'd7, 32'h000};
    vecs[7] = '{1'b1, 3'd6, 32'h0FF, 9'h0CE, 3'd6, 32'h000};
    vecs[8] = '{1'b1, 3'd7, 32'h1FF, 9'h0CE, 3'd0, 32'h0CE};
    vecs[9] = '{1'b1, 3'd4, 32'hFFFFFFFF, 9'h0CE, 3'd4, 32'h1FF};

    cycle(1'b1, 1'b0, 3'd0, 32'd0);
    cycle(1'b1, 1'b0, 3'd0, 32'd0);
    chk("reset_out", 32'(out_port), 32'h0A5);
    read_chk("reset_rd_data", 3'd0, 32'h0A5);
    read_chk("reset_rd_blink", 3'd4, 32'h0);
    read_chk("reset_rd_period", 3'd5, 32'h0);
    read_chk("reset_rd_status", 3'd6, 32'h0);

    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, vecs[i].wr, vecs[i].a, vecs[i].wd);
      chk($sformatf("vec%0d_out", i), 32'(out_port), 32'(vecs[i].exp_out));
      read_chk($sformatf("vec%0d_rd", i), vecs[i].ra, vecs[i].exp_rd);
    end

    // blink with PERIOD=4: phase restarts at the PERIOD write edge
    cycle(1'b0, 1'b1, 3'd4, 32'h003);
    cycle(1'b0, 1'b1, 3'd0, 32'h001);
    cycle(1'b0, 1'b1, 3'd5, 32'd4);
    chk("blink_k0_out", 32'(out_port), 32'h001);
    read_chk("blink_k0_status", 3'd6, 32'h2);
    for (int k = 1; k <= 12; k++) begin
      cycle(1'b0, 1'b0, 3'd6, 32'd0);
      chk($sformatf("blink_k%0d_out", k), 32'(out_port), (((k / 4) % 2) == 1) ? 32'h002 : 32'h001);
      read_chk($sformatf("blink_k%0d_status", k), 3'd6, (((k / 4) % 2) == 1) ? 32'h3 : 32'h2);
    end

    // mid-count period change: restart then toggle two edges later
    cycle(1'b0, 1'b1, 3'd5, 32'd4);
    cycle(1'b0, 1'b0, 3'd6, 32'd0);
    cycle(1'b0, 1'b0, 3'd6, 32'd0);
    read_chk("mid_pre_status", 3'd6, 32'h2);
    cycle(1'b0, 1'b1, 3'd5, 32'd2);
    read_chk("mid_wr_status", 3'd6, 32'h2);
    cycle(1'b0, 1'b0, 3'd6, 32'd0);
    read_chk("mid_p1_status", 3'd6, 32'h2);
    chk("mid_p1_out", 32'(out_port), 32'h001);
    cycle(1'b0, 1'b0, 3'd6, 32'd0);
    read_chk("mid_p2_status", 3'd6, 32'h3);
    chk("mid_p2_out", 32'(out_port), 32'h002);

    // PERIOD=0 while phase=1 forces and holds phase 0
    cycle(1'b0, 1'b1, 3'd5, 32'd0);
    chk("p0_out", 32'(out_port), 32'h001);
    read_chk("p0_status", 3'd6, 32'h0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b0, 3'd6, 32'd0);
      chk($sformatf("p0_hold%0d_out", k), 32'(out_port), 32'h001);
      read_chk($sformatf("p0_hold%0d_status", k), 3'd6, 32'h0);
    end

    // reset beats a concurrent DATA write
    cycle(1'b1, 1'b1, 3'd0, 32'h1FF);
    chk("rst_wr_out", 32'(out_port), 32'h0A5);
    read_chk("rst_wr_rd_data", 3'd0, 32'h0A5);
    read_chk("rst_wr_rd_blink", 3'd4, 32'h0);

    // random traffic against the model, out_port via the expected queue
    exp_q.delete();
    for (int n = 0; n < 500; n++) begin
      logic        rst;
      logic        wr;
      logic [2:0]  a;
      logic [2:0]  ra;
      logic [31:0] wd;
      rst = ($urandom_range(0, 63) == 0);
      wr  = ($urandom_range(0, 1) == 1);
      a   = 3'($urandom_range(0, 7));
      wd  = $urandom;
      if (a == 3'd5 && $urandom_range(0, 3) != 0) wd = 32'($urandom_range(0, 6));
      cycle(rst, wr, a, wd);
      if (exp_q.size() == 0) begin
        chk("rand_queue_empty", 32'd0, 32'd1);
      end else begin
        chk("rand_out", 32'(out_port), 32'(exp_q.pop_front()));
      end
      ra = 3'($urandom_range(0, 7));
      read_chk("rand_rd", ra, m_read(ra));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
